// File: rtl/ggt_arbiter.sv
// Round-robin arbiter sharing one ggt_top GCD core among N_REQ requesters.
// Zero operands bypass the core; a stalled core job is aborted after TIMEOUT cycles.
module ggt_arbiter #(
   parameter int N_REQ   = 4,
   parameter int WIDTH   = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_i,
   input  logic [N_REQ*WIDTH-1:0] zahl1_i,
   input  logic [N_REQ*WIDTH-1:0] zahl2_i,
   output logic [N_REQ-1:0]       grant_o,
   output logic [N_REQ-1:0]       done_o,
   output logic                   err_o,
   output logic [WIDTH-1:0]       result_o,
   output logic                   busy_o,
   output logic                   core_start_o,
   output logic [WIDTH-1:0]       core_zahl1_o,
   output logic [WIDTH-1:0]       core_zahl2_o,
   input  logic [WIDTH-1:0]       core_ergebnis_i,
   input  logic                   core_valid_i
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] last_grant;
   logic [IDX_W-1:0] idx;
   logic [CNT_W-1:0] wait_cnt;

   logic             sel_found;
   logic [IDX_W-1:0] sel_idx;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic             hi_found;
   int               hi_pos;
   int               lo_pos;
   int               sel_pos;

   function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
      onehot    = '0;
      onehot[i] = 1'b1;
   endfunction

   // Round robin: lowest requester above last_grant, else lowest overall (wrap).
   always_comb begin
      sel_found = 1'b0;
      hi_found  = 1'b0;
      hi_pos    = 0;
      lo_pos    = 0;
      sel_pos   = 0;
      sel_idx   = '0;
      sel_a     = '0;
      sel_b     = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            lo_pos    = i;
            sel_found = 1'b1;
         end
         if (req_i[i] && (i > int'(last_grant))) begin
            hi_pos   = i;
            hi_found = 1'b1;
         end
      end
      sel_pos = hi_found ? hi_pos : lo_pos;
      sel_idx = IDX_W'(sel_pos);
      for (int i = 0; i < N_REQ; i++) begin
         if (i == sel_pos) begin
            sel_a = zahl1_i[i*WIDTH +: WIDTH];
            sel_b = zahl2_i[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         last_grant   <= IDX_W'(N_REQ - 1);
         idx          <= '0;
         wait_cnt     <= '0;
         grant_o      <= '0;
         done_o       <= '0;
         err_o        <= 1'b0;
         result_o     <= '0;
         busy_o       <= 1'b0;
         core_start_o <= 1'b0;
         core_zahl1_o <= '0;
         core_zahl2_o <= '0;
      end else begin
         done_o       <= '0;
         err_o        <= 1'b0;
         core_start_o <= 1'b0;
         case (state)
            IDLE: begin
               if (sel_found) begin
                  last_grant   <= sel_idx;
                  idx          <= sel_idx;
                  core_zahl1_o <= sel_a;
                  core_zahl2_o <= sel_b;
                  if ((sel_a == '0) || (sel_b == '0)) begin
                     // gcd(x,0) = x, so the core is never started for a zero operand
                     result_o <= (sel_a == '0) ? sel_b : sel_a;
                     done_o   <= onehot(sel_idx);
                  end else begin
                     grant_o      <= onehot(sel_idx);
                     busy_o       <= 1'b1;
                     core_start_o <= 1'b1;
                     wait_cnt     <= '0;
                     state        <= START;
                  end
               end
            end
            START: begin
               wait_cnt <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               if (core_valid_i) begin
                  result_o <= core_ergebnis_i;
                  done_o   <= onehot(idx);
                  grant_o  <= '0;
                  busy_o   <= 1'b0;
                  state    <= IDLE;
               end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                  result_o <= '0;
                  done_o   <= onehot(idx);
                  err_o    <= 1'b1;
                  grant_o  <= '0;
                  busy_o   <= 1'b0;
                  state    <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            default: begin
               grant_o <= '0;
               busy_o  <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule
